adc_serial_capture: RTL and testbench

//  Parametrised successor controller for ADS1672-class serial ADCs. Pulses START,

---
 rtl/adc_serial_capture.sv | 192 +++++++++++++++++++
 tb/tb_adc_serial_capture.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_serial_capture : START/DRDY/SCLK controller for serial ADCs, NUM_CH  |
// | parallel MSB-first data lines into a valid/ready result register.        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module adc_serial_capture #(
  parameter int DATA_WIDTH  = 24,
  parameter int NUM_CH      = 1,
  parameter int SCLK_DIV    = 2,
  parameter int START_CYC   = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         measure,
  input  logic                         continuous,
  output logic                         start,
  input  logic                         drdy_n,
  output logic                         sclk,
  input  logic [NUM_CH-1:0]            sdata,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam int c_cnt_max = (TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_ph_w    = $clog2(SCLK_DIV + 1);
  localparam int c_bit_w   = $clog2(DATA_WIDTH + 1);
  localparam int c_frame_w = NUM_CH * DATA_WIDTH;

  localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_to_last    = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_ph_w-1:0]  c_ph_last    = c_ph_w'(SCLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_SHIFT   = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 drdy_meta_q, drdy_sync_q;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [c_ph_w-1:0]    ph_q, ph_d;
  logic [c_bit_w-1:0]   bit_q, bit_d;
  logic                 sclk_q, sclk_d;
  logic                 start_q, start_d;
  logic [c_frame_w-1:0] shift_q, shift_d;
  logic [c_frame_w-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  // drdy_n is asynchronous to clk; only the synchronised copy reaches the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drdy_meta_q <= 1'b1;
      drdy_sync_q <= 1'b1;
    end else begin
      drdy_meta_q <= drdy_n;
      drdy_sync_q <= drdy_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ph_q       <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      start_q    <= 1'b0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      start_q    <= start_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    start_d    = start_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = valid_q & ~data_ready;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (measure) begin
          state_d = S_START;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == c_start_last) begin
          start_d = 1'b0;
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_WAIT: begin
        // DRDY arriving on the last allowed cycle beats the timeout
        if (!drdy_sync_q) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          ph_d    = '0;
          bit_d   = '0;
        end else if (cnt_q == c_to_last) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_SHIFT: begin
        if (ph_q != c_ph_last) begin
          ph_d = ph_q + c_ph_w'(1);
        end else begin
          ph_d = '0;
          if (sclk_q) begin
            // sample on the edge that drives sclk low
            sclk_d = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              shift_d[c*DATA_WIDTH +: DATA_WIDTH] =
                {shift_q[c*DATA_WIDTH +: DATA_WIDTH-1], sdata[c]};
            end
          end else if (bit_q == c_bit_last) begin
            state_d = S_PRESENT;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + c_bit_w'(1);
          end
        end
      end
      S_PRESENT: begin
        if (!valid_q || data_ready) begin
          data_out_d = shift_q;
          valid_d    = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (continuous) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start       = start_q;
  assign sclk        = sclk_q;
  assign data_out    = data_out_q;
  assign data_valid  = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_serial_capture : directed bench for adc_serial_capture, three     |
// | parameter sets driven by a behavioural ADC model.  Revision 1.0          |
// +--------------------------------------------------------------------------+
module tb_adc_serial_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // instance a: 24-bit, SCLK_DIV=2, TIMEOUT_CYC=100
  logic a_measure, a_cont, a_start, a_drdy_n, a_sclk, a_sdata, a_valid, a_ready, a_busy, a_ovr, a_to;
  logic [23:0] a_dout;
  // instance m: 4 channels of 16 bits
  logic m_measure, m_cont, m_start, m_drdy_n, m_sclk, m_valid, m_ready, m_busy, m_ovr, m_to;
  logic [3:0]  m_sdata;
  logic [63:0] m_dout;
  // instance f: 24-bit, SCLK_DIV=1
  logic f_measure, f_cont, f_start, f_drdy_n, f_sclk, f_sdata, f_valid, f_ready, f_busy, f_ovr, f_to;
  logic [23:0] f_dout;

  adc_serial_capture #(.DATA_WIDTH(24), .NUM_CH(1), .SCLK_DIV(2), .START_CYC(4), .TIMEOUT_CYC(100)) u_a (
    .clk(clk), .rst_n(rst_n), .measure(a_measure), .continuous(a_cont), .start(a_start),
    .drdy_n(a_drdy_n), .sclk(a_sclk), .sdata(a_sdata), .data_out(a_dout), .data_valid(a_valid),
    .data_ready(a_ready), .busy(a_busy), .overrun(a_ovr), .timeout_err(a_to));

  adc_serial_capture #(.DATA_WIDTH(16), .NUM_CH(4), .SCLK_DIV(2), .START_CYC(4), .TIMEOUT_CYC(65535)) u_m (
    .clk(clk), .rst_n(rst_n), .measure(m_measure), .continuous(m_cont), .start(m_start),
    .drdy_n(m_drdy_n), .sclk(m_sclk), .sdata(m_sdata), .data_out(m_dout), .data_valid(m_valid),
    .data_ready(m_ready), .busy(m_busy), .overrun(m_ovr), .timeout_err(m_to));

  adc_serial_capture #(.DATA_WIDTH(24), .NUM_CH(1), .SCLK_DIV(1), .START_CYC(4), .TIMEOUT_CYC(65535)) u_f (
    .clk(clk), .rst_n(rst_n), .measure(f_measure), .continuous(f_cont), .start(f_start),
    .drdy_n(f_drdy_n), .sclk(f_sclk), .sdata(f_sdata), .data_out(f_dout), .data_valid(f_valid),
    .data_ready(f_ready), .busy(f_busy), .overrun(f_ovr), .timeout_err(f_to));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sclk_of(input int w);
    case (w) 0: return a_sclk; 1: return m_sclk; default: return f_sclk; endcase
  endfunction
  function automatic logic start_of(input int w);
    case (w) 0: return a_start; 1: return m_start; default: return f_start; endcase
  endfunction
  function automatic logic busy_of(input int w);
    case (w) 0: return a_busy; 1: return m_busy; default: return f_busy; endcase
  endfunction
  function automatic logic valid_of(input int w);
    case (w) 0: return a_valid; 1: return m_valid; default: return f_valid; endcase
  endfunction
  function automatic logic [63:0] dout_of(input int w);
    case (w) 0: return {40'd0, a_dout}; 1: return m_dout; default: return {40'd0, f_dout}; endcase
  endfunction
  function automatic logic [3:0] bits_at(input logic [23:0] w0, w1, w2, w3, input int idx);
    return {w3[idx], w2[idx], w1[idx], w0[idx]};
  endfunction

  task automatic set_bits(input int w, input logic [3:0] b);
    case (w) 0: a_sdata = b[0]; 1: m_sdata = b; default: f_sdata = b[0]; endcase
  endtask
  task automatic set_drdy(input int w, input logic v);
    case (w) 0: a_drdy_n = v; 1: m_drdy_n = v; default: f_drdy_n = v; endcase
  endtask
  task automatic set_measure(input int w, input logic v);
    case (w) 0: a_measure = v; 1: m_measure = v; default: f_measure = v; endcase
  endtask
  task automatic set_ready(input int w, input logic v);
    case (w) 0: a_ready = v; 1: m_ready = v; default: f_ready = v; endcase
  endtask

  // monitors: START high-cycle / rising-edge counts, overrun and timeout pulses of instance a
  int   start_hi[3]   = '{0, 0, 0};
  int   start_rise[3] = '{0, 0, 0};
  logic start_prev[3] = '{1'b0, 1'b0, 1'b0};
  int   a_ovr_cnt = 0;
  int   a_to_cnt  = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (start_of(i)) start_hi[i]++;
      if (start_of(i) && !start_prev[i]) start_rise[i]++;
      start_prev[i] = start_of(i);
    end
    if (a_ovr) a_ovr_cnt++;
    if (a_to)  a_to_cnt++;
  end

  task automatic pulse_measure(input int w);
    @(negedge clk); set_measure(w, 1'b1);
    @(negedge clk); set_measure(w, 1'b0);
  endtask

  task automatic consume(input int w);
    set_ready(w, 1'b1);
    @(negedge clk);
    set_ready(w, 1'b0);
  endtask

  task automatic wait_valid(input int w, output int n);
    n = 0;
    while (!valid_of(w) && n < 50) begin @(negedge clk); n++; end
  endtask

  // ADC model: pull DRDY low for 4 cycles, present MSB, advance one bit per sclk fall.
  // first_hi / last_fall are sample indices relative to DRDY assertion.
  task automatic run_frame(input int w, input int dw, input logic [23:0] w0, w1, w2, w3,
                           input int stop_falls, output bit ok, output int first_hi,
                           output int last_fall, output int hi_cnt);
    int t, falls;
    logic prev;
    ok = 1'b0; first_hi = -1; last_fall = -1; hi_cnt = 0; t = 0; falls = 0; prev = 1'b0;
    while (!(busy_of(w) && !start_of(w)) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) return;
    t = 0;
    set_bits(w, bits_at(w0, w1, w2, w3, dw - 1));
    set_drdy(w, 1'b0);
    while (falls < stop_falls && t < 4000) begin
      @(negedge clk); t++;
      if (t == 4) set_drdy(w, 1'b1);
      if (sclk_of(w)) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = t;
      end
      if (prev && !sclk_of(w)) begin
        falls++;
        last_fall = t;
        if (falls < dw) set_bits(w, bits_at(w0, w1, w2, w3, dw - 1 - falls));
      end
      prev = sclk_of(w);
    end
    set_drdy(w, 1'b1);
    ok = (falls == stop_falls);
  endtask

  typedef struct {
    int          w;
    int          dw;
    int          div;
    logic [23:0] c0, c1, c2, c3;
    logic [63:0] exp;
    int          exp_len;   // 2*SCLK_DIV*DATA_WIDTH
    int          exp_lat;   // samples from last sclk fall to data_valid
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  bit   ok;
  int   fh, lf, hc, n, s_hi, s_rise, s_ovr, s_to;

  initial begin
    vecs[0] = '{0, 24, 2, 24'hA5C3F1, 24'h0, 24'h0, 24'h0, 64'hA5C3F1, 96, 3};
    vecs[1] = '{0, 24, 2, 24'h800000, 24'h0, 24'h0, 24'h0, 64'h800000, 96, 3};
    vecs[2] = '{0, 24, 2, 24'h5A5A5A, 24'h0, 24'h0, 24'h0, 64'h5A5A5A, 96, 3};
    vecs[3] = '{1, 16, 2, 24'h1234, 24'hFFFF, 24'h0001, 24'h8000, 64'h8000_0001_FFFF_1234, 64, 3};
    vecs[4] = '{1, 16, 2, 24'h00FF, 24'h0F0F, 24'h3333, 24'h5555, 64'h5555_3333_0F0F_00FF, 64, 3};
    vecs[5] = '{2, 24, 1, 24'h3C0FF0, 24'h0, 24'h0, 24'h0, 64'h3C0FF0, 48, 2};

    rst_n = 1'b0;
    {a_measure, a_cont, a_sdata, a_ready} = '0; a_drdy_n = 1'b1;
    {m_measure, m_cont, m_sdata, m_ready} = '0; m_drdy_n = 1'b1;
    {f_measure, f_cont, f_sdata, f_ready} = '0; f_drdy_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a", {a_start, a_sclk, a_valid, a_busy, a_ovr, a_to, a_dout}, 64'd0);
    check("rst_m_out", {m_start, m_sclk, m_valid, m_busy, m_ovr, m_to}, 64'd0);
    check("rst_m_data", m_dout, 64'd0);
    check("rst_f", {f_start, f_sclk, f_valid, f_busy, f_ovr, f_to, f_dout}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      s_hi = start_hi[v.w];
      pulse_measure(v.w);
      run_frame(v.w, v.dw, v.c0, v.c1, v.c2, v.c3, v.dw, ok, fh, lf, hc);
      check($sformatf("v%0d_frame_done", i), ok, 1);
      check($sformatf("v%0d_drdy_to_sclk", i), (fh >= 1 && fh <= 4), 1);
      check($sformatf("v%0d_frame_len", i), lf + v.div - fh, v.exp_len);
      check($sformatf("v%0d_sclk_high", i), hc, v.exp_len / 2);
      wait_valid(v.w, n);
      check($sformatf("v%0d_valid_lat", i), n, v.exp_lat);
      check($sformatf("v%0d_data", i), dout_of(v.w), v.exp);
      check($sformatf("v%0d_idle", i), busy_of(v.w), 0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_hold", i), {valid_of(v.w), dout_of(v.w)}, {1'b1, v.exp});
      consume(v.w);
      check($sformatf("v%0d_consumed", i), valid_of(v.w), 0);
      check($sformatf("v%0d_start_len", i), start_hi[v.w] - s_hi, 4);
    end

    // continuous mode with a stalled consumer: second frame overruns, no re-START
    s_rise = start_rise[0]; s_ovr = a_ovr_cnt;
    a_cont = 1'b1;
    pulse_measure(0);
    run_frame(0, 24, 24'h111111, 24'h0, 24'h0, 24'h0, 24, ok, fh, lf, hc);
    check("cont_f1_done", ok, 1);
    wait_valid(0, n);
    check("cont_f1_data", {a_valid, a_dout}, {1'b1, 24'h111111});
    run_frame(0, 24, 24'h222222, 24'h0, 24'h0, 24'h0, 24, ok, fh, lf, hc);
    check("cont_f2_done", ok, 1);
    repeat (6) @(negedge clk);
    check("cont_overrun", a_ovr_cnt - s_ovr, 1);
    check("cont_keep_first", {a_valid, a_dout}, {1'b1, 24'h111111});
    consume(0);
    check("cont_f1_consumed", a_valid, 0);
    a_cont = 1'b0;
    run_frame(0, 24, 24'h333333, 24'h0, 24'h0, 24'h0, 24, ok, fh, lf, hc);
    wait_valid(0, n);
    check("cont_f3_data", {a_valid, a_dout}, {1'b1, 24'h333333});
    check("cont_f3_idle", a_busy, 0);
    check("cont_single_start", start_rise[0] - s_rise, 1);
    check("cont_no_more_ovr", a_ovr_cnt - s_ovr, 1);
    consume(0);

    // measure while busy is ignored; SCLK_DIV=1 toggles every cycle
    s_rise = start_rise[2];
    pulse_measure(2);
    repeat (6) @(negedge clk);
    pulse_measure(2);
    run_frame(2, 24, 24'hC0FFEE, 24'h0, 24'h0, 24'h0, 24, ok, fh, lf, hc);
    check("busy_meas_len", lf + 1 - fh, 48);
    wait_valid(2, n);
    check("busy_meas_data", f_dout, 24'hC0FFEE);
    consume(2);
    repeat (10) @(negedge clk);
    check("busy_meas_idle", {f_busy, f_valid}, 0);
    check("busy_meas_one_start", start_rise[2] - s_rise, 1);

    // DRDY never arrives: timeout after exactly 100 cycles in WAIT_DRDY
    s_to = a_to_cnt;
    pulse_measure(0);
    n = 0;
    while (a_start && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!a_to && n < 200) begin @(negedge clk); n++; end
    check("timeout_cycles", n, 100);
    check("timeout_busy_low", a_busy, 0);
    @(negedge clk);
    check("timeout_pulse", {a_to, a_busy, a_valid}, 0);
    check("timeout_count", a_to_cnt - s_to, 1);

    // asynchronous reset mid-frame, then a clean frame
    pulse_measure(0);
    run_frame(0, 24, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 10, ok, fh, lf, hc);
    repeat (2) @(negedge clk);
    check("pre_rst_sclk", {a_busy, a_sclk}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {a_start, a_sclk, a_valid, a_busy, a_ovr, a_to, a_dout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_measure(0);
    run_frame(0, 24, 24'h000001, 24'h0, 24'h0, 24'h0, 24, ok, fh, lf, hc);
    wait_valid(0, n);
    check("post_rst_data", {a_valid, a_dout}, {1'b1, 24'h000001});
    consume(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
